// File: rtl/frame_tx_crc_if.sv
// Byte-in / bit-out handshake bundle for the ISO 14443-3A transmit frame builder.
// The slave modport is the frame builder and the master modport is the application or encoder side.
interface frame_tx_crc_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_crc;
    logic        in_ready;
    logic        out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eof;
    logic [15:0] crc;
    logic        busy;

    modport master (
        output in_data, in_valid, in_last, in_crc, out_ready,
        input  in_ready, out_data, out_valid, out_sof, out_eof, crc, busy
    );

    modport slave (
        input  in_data, in_valid, in_last, in_crc, out_ready,
        output in_ready, out_data, out_valid, out_sof, out_eof, crc, busy
    );
endinterface

// File: rtl/frame_tx_crc.sv
// ISO 14443-3A transmit frame builder: serialises bytes LSb first, computes CRC_A, optionally appends CRC.
// Define FRAME_TX_PARITY_EN to append an odd parity bit to every byte; otherwise bytes are 8 bits.
module frame_tx_crc #(
    parameter logic [15:0] CRC_INIT = 16'h6363
) (
    input  logic          clk,
    input  logic          rst,
    frame_tx_crc_if.slave tx_if
);
    typedef enum logic [1:0] {IDLE, DATA, CRC_LO, CRC_HI} state_t;

`ifdef FRAME_TX_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    state_t      state_q, state_d;
    logic [8:0]  sh_q, sh_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        vld_q, vld_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        busy_q, busy_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        hold_last_q, hold_last_d;
    logic        cur_last_q, cur_last_d;
    logic        last_acc_q, last_acc_d;
    logic        crc_en_q, crc_en_d;
    logic        rdy_en_q;
    logic        in_ready;
    logic        accept;
    logic        consume;
    logic        byte_done;
    logic        need_byte;

    function automatic logic [8:0] frame_byte(input logic [7:0] b);
        return {~^b, b};
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return (c >> 1) ^ ((b ^ c[0]) ? 16'h8408 : 16'h0000);
    endfunction

    // No new bytes once the last data byte of the frame has been taken.
    assign in_ready  = rdy_en_q & ~hold_full_q & ~last_acc_q;
    assign accept    = tx_if.in_valid & in_ready;
    assign consume   = vld_q & tx_if.out_ready;
    assign byte_done = consume & (cnt_q == LAST_BIT);
    assign need_byte = (state_q == DATA) & (byte_done ? ~cur_last_q : ~vld_q);

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        vld_d       = vld_q;
        sof_d       = sof_q;
        busy_d      = busy_q;
        crc_d       = crc_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        hold_last_d = hold_last_q;
        cur_last_d  = cur_last_q;
        last_acc_d  = last_acc_q;
        crc_en_d    = crc_en_q;

        if (consume) begin
            sof_d = 1'b0;
            if (state_q == DATA && cnt_q < 4'd8) begin
                crc_d = crc_step(crc_q, sh_q[0]);
            end
            sh_d  = {1'b0, sh_q[8:1]};
            cnt_d = cnt_q + 4'd1;
            if (byte_done) begin
                vld_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    crc_d      = CRC_INIT;
                    crc_en_d   = tx_if.in_crc;
                    cur_last_d = tx_if.in_last;
                    last_acc_d = tx_if.in_last;
                    sh_d       = frame_byte(tx_if.in_data);
                    cnt_d      = 4'd0;
                    vld_d      = 1'b1;
                    sof_d      = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = DATA;
                end
            end
            DATA: begin
                // A byte arriving on the edge the shifter frees up bypasses the holding register.
                if (need_byte && hold_full_q) begin
                    sh_d        = frame_byte(hold_q);
                    cnt_d       = 4'd0;
                    vld_d       = 1'b1;
                    hold_full_d = 1'b0;
                    cur_last_d  = hold_last_q;
                end else if (need_byte && accept) begin
                    sh_d       = frame_byte(tx_if.in_data);
                    cnt_d      = 4'd0;
                    vld_d      = 1'b1;
                    cur_last_d = tx_if.in_last;
                end else if (accept) begin
                    hold_d      = tx_if.in_data;
                    hold_full_d = 1'b1;
                    hold_last_d = tx_if.in_last;
                end
                if (accept) begin
                    last_acc_d = tx_if.in_last;
                end
                if (byte_done && cur_last_q) begin
                    if (crc_en_q) begin
                        // crc_d already includes d7 when there is no parity bit.
                        sh_d    = frame_byte(crc_d[7:0]);
                        cnt_d   = 4'd0;
                        vld_d   = 1'b1;
                        state_d = CRC_LO;
                    end else begin
                        busy_d     = 1'b0;
                        last_acc_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            CRC_LO: begin
                if (byte_done) begin
                    sh_d    = frame_byte(crc_q[15:8]);
                    cnt_d   = 4'd0;
                    vld_d   = 1'b1;
                    state_d = CRC_HI;
                end
            end
            default: begin
                if (byte_done) begin
                    busy_d     = 1'b0;
                    last_acc_d = 1'b0;
                    state_d    = IDLE;
                end
            end
        endcase

        eof_d = vld_d & (cnt_d == LAST_BIT) &
                (((state_d == DATA) & cur_last_d & ~crc_en_d) | (state_d == CRC_HI));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            vld_q       <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
            crc_q       <= CRC_INIT;
            hold_full_q <= 1'b0;
            cur_last_q  <= 1'b0;
            last_acc_q  <= 1'b0;
            crc_en_q    <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            busy_q      <= busy_d;
            crc_q       <= crc_d;
            hold_full_q <= hold_full_d;
            cur_last_q  <= cur_last_d;
            last_acc_q  <= last_acc_d;
            crc_en_q    <= crc_en_d;
            rdy_en_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        hold_q      <= hold_d;
        hold_last_q <= hold_last_d;
    end

    assign tx_if.in_ready  = in_ready;
    assign tx_if.out_data  = sh_q[0];
    assign tx_if.out_valid = vld_q;
    assign tx_if.out_sof   = sof_q;
    assign tx_if.out_eof   = eof_q;
    assign tx_if.crc       = crc_q;
    assign tx_if.busy      = busy_q;
endmodule

// File: tb/tb_frame_tx_crc.sv
// Randomised scoreboard bench for frame_tx_crc: expected bit stream and final CRC per frame
// come from a byte-level model; a monitor pops and compares on every consumed bit.
module tb_frame_tx_crc;
`ifdef FRAME_TX_PARITY_EN
    localparam int BPB = 9;
`else
    localparam int BPB = 8;
`endif

    typedef struct packed {logic d; logic sof; logic eof;} bit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_tx_crc_if tif();
    frame_tx_crc dut (.clk(clk), .rst(rst), .tx_if(tif));

    int checks = 0;
    int errors = 0;
    bit_t exp_q[$];
    logic [15:0] crc_q[$];
    int rdy_pct = 100;
    int bit_total = 0;
    int busy_cnt = 0;
    int last_busy = 0;
    logic [7:0] fbuf [16];
    int flen = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %04h want %04h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // CRC_A over the first n bytes of fbuf, bit by bit, LSb first.
    function automatic logic [15:0] model_crc(input int n);
        logic [15:0] c;
        c = 16'h6363;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                if (fbuf[i][k] ^ c[0]) c = (c >> 1) ^ 16'h8408;
                else c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic push_byte(input logic [7:0] b, input bit first, input bit last);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back('{b[k], first && k == 0, last && BPB == 8 && k == 7});
        end
        if (BPB == 9) begin
            exp_q.push_back('{($countones(b) % 2) == 0, 1'b0, last});
        end
    endtask

    task automatic push_expected(input bit crcflag, input bit use_ovr, input logic [15:0] ovr);
        logic [15:0] c;
        c = model_crc(flen);
        for (int i = 0; i < flen; i++) begin
            push_byte(fbuf[i], i == 0, (i == flen - 1) && !crcflag);
        end
        if (crcflag) begin
            push_byte(c[7:0], 1'b0, 1'b0);
            push_byte(c[15:8], 1'b0, 1'b1);
        end
        crc_q.push_back(use_ovr ? ovr : c);
    endtask

    task automatic drive_bytes(input int nsend, input bit crcflag, input int vld_pct);
        bit got;
        for (int i = 0; i < nsend; i++) begin
            while (int'($urandom_range(99)) >= vld_pct) begin
                @(posedge clk); #1;
            end
            tif.in_data  = fbuf[i];
            tif.in_valid = 1'b1;
            tif.in_last  = (i == flen - 1);
            tif.in_crc   = (i == 0) ? crcflag : 1'($urandom_range(1));
            got = 1'b0;
            for (int t = 0; t < 3000 && !got; t++) begin
                @(negedge clk);
                got = tif.in_ready;
                @(posedge clk); #1;
            end
            tif.in_valid = 1'b0;
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout byte %0d got no in_ready want accept", i);
            end
        end
        tif.in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || crc_q.size() != 0) && t < 8000) begin
            @(posedge clk); #1;
            t++;
        end
        chk_int("drain_pending_items", exp_q.size() + crc_q.size(), 0);
    endtask

    // Ready driver for the bit side.
    initial begin
        tif.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            tif.out_ready = (int'($urandom_range(99)) < rdy_pct);
        end
    end

    // Monitor: compares every consumed bit, stall stability, and post-frame state.
    initial begin
        bit_t e;
        logic prev_d, prev_sof, prev_eof;
        bit stall_prev, post_eof;
        stall_prev = 1'b0;
        post_eof = 1'b0;
        prev_d = 1'b0; prev_sof = 1'b0; prev_eof = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                crc_q.delete();
                stall_prev = 1'b0;
                post_eof = 1'b0;
                busy_cnt = 0;
            end else begin
                if (post_eof) begin
                    post_eof = 1'b0;
                    chk1("busy_after_eof", tif.busy, 1'b0);
                    chk1("valid_after_eof", tif.out_valid, 1'b0);
                    if (crc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL crc_final got %04h want no frame pending", tif.crc);
                    end else begin
                        chk16("crc_final", tif.crc, crc_q.pop_front());
                    end
                    last_busy = busy_cnt;
                    busy_cnt = 0;
                end
                if (tif.busy) busy_cnt++;
                if (stall_prev) begin
                    chk1("stall_valid", tif.out_valid, 1'b1);
                    chk1("stall_data", tif.out_data, prev_d);
                    chk1("stall_sof", tif.out_sof, prev_sof);
                    chk1("stall_eof", tif.out_eof, prev_eof);
                end
                if (tif.out_valid && tif.out_ready) begin
                    bit_total++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bit got %0b want no bit", tif.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk1("bit_data", tif.out_data, e.d);
                        chk1("bit_sof", tif.out_sof, e.sof);
                        chk1("bit_eof", tif.out_eof, e.eof);
                        if (e.eof) post_eof = 1'b1;
                    end
                end
                stall_prev = tif.out_valid && !tif.out_ready;
                prev_d   = tif.out_data;
                prev_sof = tif.out_sof;
                prev_eof = tif.out_eof;
            end
        end
    end

    initial begin
        int base, t, n;
        bit cf;
        tif.in_data = 8'h00;
        tif.in_valid = 1'b0;
        tif.in_last = 1'b0;
        tif.in_crc = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_in_ready", tif.in_ready, 1'b0);
        chk1("rst_out_valid", tif.out_valid, 1'b0);
        chk1("rst_out_data", tif.out_data, 1'b0);
        chk1("rst_out_sof", tif.out_sof, 1'b0);
        chk1("rst_out_eof", tif.out_eof, 1'b0);
        chk1("rst_busy", tif.busy, 1'b0);
        chk16("rst_crc", tif.crc, 16'h6363);
        rst = 1'b0;
        chk1("ready_before_first_edge", tif.in_ready, 1'b0);
        @(posedge clk); #1;
        chk1("ready_after_rst", tif.in_ready, 1'b1);

        // {00,00} with CRC, back to back, no stalls.
        rdy_pct = 100;
        fbuf[0] = 8'h00; fbuf[1] = 8'h00; flen = 2;
        push_expected(1'b1, 1'b1, 16'h1EA0);
        drive_bytes(2, 1'b1, 100);
        wait_idle();
        chk_int("busy_cycles_0000", last_busy, 4 * BPB);

        // {12,34} with CRC.
        fbuf[0] = 8'h12; fbuf[1] = 8'h34; flen = 2;
        push_expected(1'b1, 1'b1, 16'hCF26);
        drive_bytes(2, 1'b1, 100);
        wait_idle();
        chk_int("busy_cycles_1234", last_busy, 4 * BPB);

        // Single byte, no CRC.
        fbuf[0] = 8'h00; flen = 1;
        push_expected(1'b0, 1'b0, 16'h0000);
        drive_bytes(1, 1'b0, 100);
        wait_idle();
        chk_int("busy_cycles_single", last_busy, BPB);

        // Reset after 5 bits of a 3-byte frame.
        fbuf[0] = 8'hA5; fbuf[1] = 8'h3C; fbuf[2] = 8'hF0; flen = 3;
        base = bit_total;
        push_expected(1'b1, 1'b0, 16'h0000);
        drive_bytes(2, 1'b1, 100);
        t = 0;
        while (bit_total < base + 5 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk_int("bits_before_reset", bit_total - base, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk1("midrst_out_valid", tif.out_valid, 1'b0);
        chk16("midrst_crc", tif.crc, 16'h6363);
        chk1("midrst_busy", tif.busy, 1'b0);
        chk1("midrst_in_ready", tif.in_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        fbuf[0] = 8'h12; fbuf[1] = 8'h34; flen = 2;
        push_expected(1'b1, 1'b1, 16'hCF26);
        drive_bytes(2, 1'b1, 100);
        wait_idle();

        // Random frames with stalls on both sides.
        for (int f = 0; f < 300; f++) begin
            n = int'($urandom_range(10, 1));
            cf = 1'($urandom_range(1));
            for (int i = 0; i < n; i++) fbuf[i] = 8'($urandom);
            flen = n;
            case ($urandom_range(2))
                0: rdy_pct = 100;
                1: rdy_pct = 70;
                default: rdy_pct = 40;
            endcase
            push_expected(cf, 1'b0, 16'h0000);
            drive_bytes(n, cf, (f % 3 == 0) ? 100 : 50);
        end
        rdy_pct = 100;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
